sram_req_ctrl: RTL and testbench

- Initiator-side controller for a single-port synchronous SRAM macro with 1-cycle read latency, such as the 64x24 sram22 macro.
- Accepts valid/ready read/write requests from a client and drives the macro's we/wmask/addr/din ports. It captures dout on the cycle after each read and returns read data through a backpressured response FIFO.
- After reset it zero-fills the whole array, because the macro does not power up initialised.

---
 rtl/sram_req_ctrl_if.sv | 25 ++
 rtl/sram_req_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_sram_req_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_req_ctrl_if.sv
// Client-side request/response bundle for sram_req_ctrl.
// The client drives the master modport; the controller uses the slave modport.
interface sram_req_ctrl_if #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 6
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_req_ctrl.sv
// Request controller for a 1-cycle-latency single-port SRAM macro with zero-fill after reset.
// Optional macro SRAM_CTRL_WRACK_EN: accepted writes also return a response carrying the written data.
module sram_req_ctrl_chk #(
    parameter int CNT_W     = 2,
    parameter int RSP_DEPTH = 3
) (
    input logic             i_clk,
    input logic             i_rst,
    input logic             i_push,
    input logic             i_pop,
    input logic [CNT_W-1:0] i_count
);
    // The credit rule must never let a push land on a full FIFO.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_push && !i_pop && (i_count == CNT_W'(RSP_DEPTH))));
endmodule

module sram_req_ctrl #(
    parameter int DATA_WIDTH  = 24,
    parameter int ADDR_WIDTH  = 6,
    parameter int WMASK_WIDTH = 1,
    parameter int RSP_DEPTH   = 3
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    sram_req_ctrl_if.slave         io_req,
    output logic                   o_init_done,
    output logic                   o_sram_we,
    output logic [WMASK_WIDTH-1:0] o_sram_wmask,
    output logic [ADDR_WIDTH-1:0]  o_sram_addr,
    output logic [DATA_WIDTH-1:0]  o_sram_din,
    input  logic [DATA_WIDTH-1:0]  i_sram_dout
);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_fifo [RSP_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W:0]        w_used;
    logic                  w_req_ready;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_push_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(RSP_DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Credits cover queued entries plus the read whose data arrives next cycle.
    assign w_used      = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_req_ready = (r_state == ST_RUN) && (w_used < (CNT_W + 1)'(RSP_DEPTH));
    assign w_accept    = io_req.req_valid && w_req_ready;
    assign w_push      = r_inflight;
    assign w_pop       = (r_count != {CNT_W{1'b0}}) && io_req.rsp_ready;

`ifdef SRAM_CTRL_WRACK_EN
    logic                  r_inflight_wr;
    logic [DATA_WIDTH-1:0] r_wack_data;

    // Remember whether the pending entry is a write acknowledge and its data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_inflight_wr <= 1'b0;
            r_wack_data   <= {DATA_WIDTH{1'b0}};
        end else begin
            r_inflight_wr <= w_accept && io_req.req_we;
            r_wack_data   <= io_req.req_wdata;
        end
    end

    assign w_push_data = r_inflight_wr ? r_wack_data : i_sram_dout;
`else
    assign w_push_data = i_sram_dout;
`endif

    // State register, fill counter and in-flight flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_INIT;
            r_init_cnt <= {ADDR_WIDTH{1'b0}};
            r_inflight <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt + ADDR_WIDTH'(1);
            end else begin
                r_init_cnt <= r_init_cnt;
            end
`ifdef SRAM_CTRL_WRACK_EN
            r_inflight <= w_accept;
`else
            r_inflight <= w_accept && !io_req.req_we;
`endif
        end
    end

    // Next state and macro drive; the macro registers these on the next edge.
    always_comb begin
        w_state_nxt = r_state;
        o_sram_we   = 1'b0;
        o_sram_addr = {ADDR_WIDTH{1'b0}};
        o_sram_din  = {DATA_WIDTH{1'b0}};
        case (r_state)
            ST_INIT: begin
                o_sram_we   = 1'b1;
                o_sram_addr = r_init_cnt;
                if (r_init_cnt == {ADDR_WIDTH{1'b1}}) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_INIT;
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    o_sram_we   = io_req.req_we;
                    o_sram_addr = io_req.req_addr;
                    if (io_req.req_we) begin
                        o_sram_din = io_req.req_wdata;
                    end else begin
                        o_sram_din = {DATA_WIDTH{1'b0}};
                    end
                end else begin
                    o_sram_we = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // Response FIFO pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Response FIFO storage.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_push_data;
        end
    end

    assign io_req.req_ready = w_req_ready;
    assign io_req.rsp_valid = (r_count != {CNT_W{1'b0}});
    assign io_req.rsp_rdata = r_fifo[r_rd_ptr];
    assign o_init_done      = (r_state == ST_RUN);
    assign o_sram_wmask     = {WMASK_WIDTH{1'b1}};

    sram_req_ctrl_chk #(.CNT_W(CNT_W), .RSP_DEPTH(RSP_DEPTH)) u_chk (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_count (r_count)
    );
endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl with a behavioural SRAM and a response scoreboard.
// Honours SRAM_CTRL_WRACK_EN the same way as the design.
module tb_sram_req_ctrl;
    localparam int DW    = 24;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_done;
    logic          sram_we;
    logic [0:0]    sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [DW-1:0]    sb[$];
    int               pop_cyc[$];
    logic [DW-1:0]    model [DEPTH];
    logic [DW-1:0]    mem   [DEPTH];
    logic [DEPTH-1:0] written = '0;

    always #5 clk = ~clk;

    sram_req_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sram_req_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(1), .RSP_DEPTH(3)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .io_req       (bus),
        .o_init_done  (init_done),
        .o_sram_we    (sram_we),
        .o_sram_wmask (sram_wmask),
        .o_sram_addr  (sram_addr),
        .o_sram_din   (sram_din),
        .i_sram_dout  (sram_dout)
    );

    // Macro model: unwritten words return garbage so the zero-fill matters.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sram_we && sram_wmask[0]) begin
            mem[sram_addr]     <= sram_din;
            written[sram_addr] <= 1'b1;
        end else if (!sram_we) begin
            sram_dout <= written[sram_addr] ? mem[sram_addr] : (24'hBAD000 ^ {18'b0, sram_addr});
        end
    end

    // Response monitor: every completed handshake is checked against the scoreboard.
    always @(negedge clk) begin
        logic [DW-1:0] exp_d;
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_rsp observed=%06h expected=none", bus.rsp_rdata);
            end
            if (sb.size() != 0) begin
                exp_d = sb.pop_front();
                tests++;
                assert (bus.rsp_rdata === exp_d) else begin
                    fails++;
                    $error("FAIL rsp_data observed=%06h expected=%06h", bus.rsp_rdata, exp_d);
                end
            end
            pop_cyc.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, output int waits);
        waits          = 0;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        while (!bus.req_ready && waits < 300) begin
            tick();
            waits++;
        end
        if (!bus.req_ready) begin
            chk("accept_timeout", {63'b0, bus.req_ready}, 64'd1);
        end else if (we) begin
            model[a] = d;
`ifdef SRAM_CTRL_WRACK_EN
            sb.push_back(d);
`endif
        end else begin
            sb.push_back(model[a]);
        end
        tick();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
        tick();
    endtask

    task automatic fill_check();
        chk("fill_init_done_low", {63'b0, init_done}, 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            chk("fill_we_addr_din", {33'b0, sram_we, sram_addr, sram_din},
                {33'b0, 1'b1, AW'(i), {DW{1'b0}}});
            tick();
        end
        chk("fill_len_we_low", {63'b0, sram_we}, 64'd0);
        chk("fill_init_done", {63'b0, init_done}, 64'd1);
        chk("fill_req_ready", {63'b0, bus.req_ready}, 64'd1);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    initial begin
        int w;
        int stalls;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        rst           = 1'b1;
        tick();
        tick();
        chk("rst_init_done", {63'b0, init_done}, 64'd0);
        chk("rst_req_ready", {63'b0, bus.req_ready}, 64'd0);
        chk("rst_rsp_valid", {63'b0, bus.rsp_valid}, 64'd0);
        rst = 1'b0;
        fill_check();

        // Zero-filled location reads back zero.
        bus.rsp_ready = 1'b1;
        issue(1'b0, 6'd17, '0, w);
        drain();

        // Write then read the same address back to back.
        issue(1'b1, 6'd5, 24'hA5A5A5, w);
        issue(1'b0, 6'd5, '0, w);
        chk("raw_not_early", {63'b0, bus.rsp_valid}, 64'd0);
        tick();
        chk("raw_valid", {63'b0, bus.rsp_valid}, 64'd1);
        chk("raw_data", 64'(bus.rsp_rdata), 64'hA5A5A5);
        drain();

        // Preload then stream eight reads.
        for (int i = 0; i < 8; i++) issue(1'b1, AW'(i), DW'(i * 24'h010101), w);
        drain();
        pop_cyc.delete();
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, AW'(i), '0, w);
            stalls += w;
        end
        drain();
        chk("stream_stalls", 64'(stalls), 64'd0);
        chk("stream_count", 64'(pop_cyc.size()), 64'd8);
        chk("stream_consec", 64'(pop_cyc[7] - pop_cyc[0]), 64'd7);

        // Backpressure: three credits, then stall with stable output.
        bus.rsp_ready = 1'b0;
        stalls = 0;
        for (int i = 1; i < 4; i++) begin
            issue(1'b0, AW'(i), '0, w);
            stalls += w;
        end
        chk("bp_no_stall", 64'(stalls), 64'd0);
        chk("bp_ready_low", {63'b0, bus.req_ready}, 64'd0);
        chk("bp_head", 64'(bus.rsp_rdata), 64'h010101);
        tick();
        tick();
        tick();
        chk("bp_valid_stable", {63'b0, bus.rsp_valid}, 64'd1);
        chk("bp_data_stable", 64'(bus.rsp_rdata), 64'h010101);
        chk("bp_ready_still_low", {63'b0, bus.req_ready}, 64'd0);
        bus.rsp_ready = 1'b1;
        drain();
        chk("bp_ready_back", {63'b0, bus.req_ready}, 64'd1);

        // Reset with two queued responses and one read in flight.
        bus.rsp_ready = 1'b0;
        for (int i = 4; i < 7; i++) issue(1'b0, AW'(i), '0, w);
        rst = 1'b1;
        sb.delete();
        tick();
        chk("mid_rst_rsp_valid", {63'b0, bus.rsp_valid}, 64'd0);
        chk("mid_rst_init_done", {63'b0, init_done}, 64'd0);
        rst = 1'b0;
        fill_check();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) issue(1'b0, AW'(i), '0, w);
        drain();

        // Write to the top address: acknowledged only with the option enabled.
        issue(1'b1, 6'd63, 24'h123456, w);
`ifdef SRAM_CTRL_WRACK_EN
        tick();
        chk("wrack_valid", {63'b0, bus.rsp_valid}, 64'd1);
        chk("wrack_data", 64'(bus.rsp_rdata), 64'h123456);
`else
        for (int i = 0; i < 4; i++) begin
            chk("no_wrack", {63'b0, bus.rsp_valid}, 64'd0);
            tick();
        end
`endif
        drain();
        issue(1'b0, 6'd63, '0, w);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
